// File: rtl/delay_timer_core.sv
// Programmable delay timer: a prescaled down-counter with one-shot or periodic
// expiry, a sticky interrupt and an 8-bit expiry counter.
module delay_timer_core #(
  parameter int C_CNT_WIDTH = 32,
  parameter int C_PSC_WIDTH = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   auto_reload,
  input  logic                   irq_en,
  input  logic                   irq_clear,
  input  logic [C_CNT_WIDTH-1:0] load_value,
  input  logic [C_PSC_WIDTH-1:0] prescale,
  output logic                   busy,
  output logic [C_CNT_WIDTH-1:0] count,
  output logic                   done_pulse,
  output logic                   irq,
  output logic [7:0]             expire_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [C_PSC_WIDTH-1:0] psc, psc_nxt;
  logic [C_PSC_WIDTH-1:0] psc_lim, psc_lim_nxt;
  logic [C_CNT_WIDTH-1:0] count_nxt;
  logic                   tick;
  logic                   expiry;
  logic                   irq_pend;

  // Next-state logic. A start with a zero load expires immediately, so it is
  // treated as an expiry event and lands directly in DONE.
  always_comb begin
    state_nxt   = state;
    psc_nxt     = psc;
    psc_lim_nxt = psc_lim;
    count_nxt   = count;
    tick        = 1'b0;
    expiry      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nxt = IDLE;
        if (start && !stop) begin
          count_nxt   = load_value;
          psc_nxt     = '0;
          psc_lim_nxt = prescale;
          if (load_value == '0) begin
            state_nxt = DONE;
            expiry    = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          psc_nxt   = '0;
        end else if (start) begin
          count_nxt   = load_value;
          psc_nxt     = '0;
          psc_lim_nxt = prescale;
          if (load_value == '0) begin
            state_nxt = DONE;
            expiry    = 1'b1;
          end
        end else begin
          tick    = (psc == psc_lim);
          psc_nxt = tick ? '0 : psc + C_PSC_WIDTH'(1);
          if (tick) begin
            if (count > C_CNT_WIDTH'(1)) begin
              count_nxt = count - C_CNT_WIDTH'(1);
            end else begin
              expiry    = 1'b1;
              count_nxt = '0;
              if (auto_reload && (load_value != '0)) begin
                count_nxt   = load_value;
                psc_lim_nxt = prescale;
              end else begin
                state_nxt = DONE;
              end
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register. The latched prescale limit is only read in RUN, after a
  // load has written it, so it needs no reset.
  always_ff @(posedge ACLK) begin
    psc_lim <= psc_lim_nxt;
    if (!ARESETN) begin
      state      <= IDLE;
      psc        <= '0;
      count      <= '0;
      done_pulse <= 1'b0;
      irq_pend   <= 1'b0;
      expire_cnt <= '0;
    end else begin
      state      <= state_nxt;
      psc        <= psc_nxt;
      count      <= count_nxt;
      done_pulse <= expiry;
      irq_pend   <= expiry | (irq_pend & ~irq_clear);
      expire_cnt <= expire_cnt + 8'(expiry);
    end
  end

  assign busy = (state == RUN);
  assign irq  = irq_pend & irq_en;

endmodule

// File: tb/tb_delay_timer_core.sv
// Directed bench for delay_timer_core: one-shot, periodic, abort/restart,
// zero load, irq set/clear race, reset mid-run, max prescale and counter wrap.
module tb_delay_timer_core;

  localparam int CW = 32;
  localparam int PW = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          start, stop, auto_reload, irq_en, irq_clear;
  logic [CW-1:0] load_value;
  logic [PW-1:0] prescale;
  logic          busy, done_pulse, irq;
  logic [CW-1:0] count;
  logic [7:0]    expire_cnt;

  int n_pass = 0;
  int n_tot  = 0;
  int n_done;

  delay_timer_core #(.C_CNT_WIDTH(CW), .C_PSC_WIDTH(PW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .stop(stop),
    .auto_reload(auto_reload), .irq_en(irq_en), .irq_clear(irq_clear),
    .load_value(load_value), .prescale(prescale), .busy(busy), .count(count),
    .done_pulse(done_pulse), .irq(irq), .expire_cnt(expire_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    ARESETN = 1'b0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    irq_en = 1'b1; irq_clear = 1'b0; load_value = '0; prescale = '0;
    tick(); tick();
    ARESETN = 1'b1;
  endtask

  initial begin
    // Reset values, then the first start in the first cycle out of reset.
    do_reset();
    ARESETN = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", count, 0);
    chk("rst_done", 32'(done_pulse), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_expire", 32'(expire_cnt), 0);

    // One-shot L=3 P=1: busy T+1..T+6, done only at T+7.
    ARESETN = 1'b1; start = 1'b1; load_value = 3; prescale = 1;
    tick(); start = 1'b0;
    chk("os_count_load", count, 3);
    for (int n = 1; n <= 7; n++) begin
      if (n > 1) tick();
      chk($sformatf("os_done_T%0d", n), 32'(done_pulse), 32'(n == 7));
      chk($sformatf("os_busy_T%0d", n), 32'(busy), 32'(n <= 6));
    end
    chk("os_expire", 32'(expire_cnt), 1);
    chk("os_irq", 32'(irq), 1);
    chk("os_count_end", count, 0);
    tick();
    chk("os_done_after", 32'(done_pulse), 0);
    irq_en = 1'b0; #1;
    chk("irq_gated", 32'(irq), 0);
    irq_en = 1'b1; #1;
    chk("irq_regated", 32'(irq), 1);
    irq_clear = 1'b1; tick(); irq_clear = 1'b0;
    chk("irq_cleared", 32'(irq), 0);

    // Periodic L=2 P=0: done at T+3, T+5, T+7, then stop.
    do_reset();
    auto_reload = 1'b1; load_value = 2; prescale = 0; start = 1'b1;
    tick(); start = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      if (n > 1) tick();
      chk($sformatf("per_done_T%0d", n), 32'(done_pulse), 32'(n == 3 || n == 5 || n == 7));
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("per_busy_stop", 32'(busy), 0);
    chk("per_expire", 32'(expire_cnt), 3);
    chk("per_count_held", count, 2);
    chk("per_done_stop", 32'(done_pulse), 0);

    // Abort at T+4 holds count 7, restart expires 11 cycles later.
    do_reset();
    load_value = 10; prescale = 0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("ab_count_T4", count, 7);
    stop = 1'b1; tick(); stop = 1'b0;
    n_done = 0;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) tick();
      if (done_pulse) n_done++;
    end
    chk("ab_count_held", count, 7);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_no_done", 32'(n_done), 0);
    chk("ab_no_expire", 32'(expire_cnt), 0);
    chk("ab_no_irq", 32'(irq), 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      if (n > 1) tick();
      chk($sformatf("ab_re_done_T%0d", n), 32'(done_pulse), 32'(n == 11));
    end

    // Zero load: done at T+1, never busy.
    do_reset();
    load_value = 0; start = 1'b1;
    tick(); start = 1'b0;
    chk("z_done", 32'(done_pulse), 1);
    chk("z_busy", 32'(busy), 0);
    tick();
    chk("z_done_after", 32'(done_pulse), 0);
    chk("z_busy_after", 32'(busy), 0);

    // Expiry coincident with irq_clear: set wins. Second start issued in DONE.
    do_reset();
    load_value = 1; prescale = 0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("ic_pre_irq", 32'(irq), 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("ic_busy", 32'(busy), 1);
    irq_clear = 1'b1; tick(); irq_clear = 1'b0;
    chk("ic_done", 32'(done_pulse), 1);
    chk("ic_irq_kept", 32'(irq), 1);
    chk("ic_expire", 32'(expire_cnt), 2);

    // Start and stop together in RUN: stop wins.
    do_reset();
    load_value = 5; prescale = 0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    chk("ss_count", count, 4);
    n_done = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (done_pulse) n_done++;
    end
    chk("ss_no_done", 32'(n_done), 0);

    // Reset mid-run L=100 P=3 at T+20.
    do_reset();
    load_value = 100; prescale = 3; start = 1'b1;
    tick(); start = 1'b0;
    for (int n = 1; n < 20; n++) tick();
    chk("mr_busy_pre", 32'(busy), 1);
    ARESETN = 1'b0; tick(); ARESETN = 1'b1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_count", count, 0);
    chk("mr_done", 32'(done_pulse), 0);
    chk("mr_irq", 32'(irq), 0);
    chk("mr_expire", 32'(expire_cnt), 0);
    n_done = 0;
    for (int n = 0; n < 450; n++) begin
      tick();
      if (done_pulse || busy) n_done++;
    end
    chk("mr_quiet", 32'(n_done), 0);

    // Max prescale (255 with 8-bit width): L=2 expires at T+2*256+1 = T+513.
    do_reset();
    load_value = 2; prescale = 8'hff; start = 1'b1;
    tick(); start = 1'b0;
    n_done = 0;
    for (int n = 1; n < 513; n++) begin
      if (n > 1) tick();
      if (done_pulse) n_done++;
    end
    chk("mp_no_early", 32'(n_done), 0);
    chk("mp_count_mid", count, 1);
    tick();
    chk("mp_done", 32'(done_pulse), 1);

    // 256 periodic expiries L=1 P=0: counter wraps to 0, irq still pending.
    do_reset();
    auto_reload = 1'b1; load_value = 1; prescale = 0; start = 1'b1;
    tick(); start = 1'b0;
    for (int n = 1; n < 256; n++) tick();
    chk("wr_expire_255", 32'(expire_cnt), 255);
    tick();
    chk("wr_expire_0", 32'(expire_cnt), 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("wr_expire_stop", 32'(expire_cnt), 0);
    chk("wr_irq", 32'(irq), 1);
    chk("wr_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/delay_timer_core.md
DELAY_TIMER_CORE -- requirements
Module: delay_timer_core

Interface
REQ-001 SHALL have parameter C_CNT_WIDTH, default 32: width of the delay count and load value.
REQ-002 SHALL have parameter C_PSC_WIDTH, default 16: width of the prescale value.
REQ-003 SHALL have port ACLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port ARESETN, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle pulse from the register bank that loads and starts the timer.
REQ-006 SHALL have port stop, input, 1: single-cycle pulse that aborts a running delay.
REQ-007 SHALL have port auto_reload, input, 1: level; 1 selects periodic mode, 0 selects one-shot mode.
REQ-008 SHALL have port irq_en, input, 1: level that gates the irq output.
REQ-009 SHALL have port irq_clear, input, 1: single-cycle pulse that clears the sticky interrupt.
REQ-010 SHALL have port load_value, input, C_CNT_WIDTH: delay length in ticks.
REQ-011 SHALL have port prescale, input, C_PSC_WIDTH: one tick occurs every prescale+1 clocks.
REQ-012 SHALL have port busy, output, 1: high while state is RUN.
REQ-013 SHALL have port count, output, C_CNT_WIDTH: remaining ticks (registered).
REQ-014 SHALL have port done_pulse, output, 1: one-cycle pulse on each expiry.
REQ-015 SHALL have port irq, output, 1: equals irq_pend AND irq_en.
REQ-016 SHALL have port expire_cnt, output, 8: count of expiries, wraps from 255 to 0.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL load count=load_value, clear the prescaler to 0, and go to RUN; if load_value=0 it SHALL go to DONE instead.
REQ-019 In RUN, the prescaler SHALL increment each cycle; when prescaler==prescale it SHALL wrap to 0 and generate a tick that same cycle.
REQ-020 On a tick with count>1, count SHALL decrement by 1.
REQ-021 On a tick with count==1, an expiry event SHALL occur.
REQ-022 On expiry, count SHALL be set to 0, done_pulse SHALL be 1 the next cycle, expire_cnt SHALL increment by 1, and irq_pend SHALL be set.
REQ-023 On expiry with auto_reload=1, count SHALL reload from load_value, the FSM SHALL stay in RUN, and the prescaler SHALL continue from 0.
REQ-024 On expiry with auto_reload=0, the FSM SHALL go to DONE.
REQ-025 Expiry latency: with start sampled in cycle T, the first done_pulse SHALL be high in cycle T + L*(P+1) + 1, where L=load_value and P=prescale sampled at start; L=0 gives T+1.
REQ-026 load_value and prescale SHALL be sampled only at start and at auto-reload; changes during a tick period SHALL apply to the next reload only.
REQ-027 DONE SHALL last exactly one cycle, with done_pulse=1, then go to IDLE unless start=1 in that cycle.
REQ-028 Auto-reload with load_value=0 at the reload point SHALL behave as one-shot and go to DONE.
REQ-029 In RUN, stop=1 SHALL go to IDLE, hold count at its current value, and produce no done_pulse, irq or expire_cnt change.
REQ-030 In RUN, start=1 SHALL restart the delay (reload count, prescaler=0) and suppress any expiry in that cycle.
REQ-031 When start and stop are both 1 in the same cycle, stop SHALL win.
REQ-032 A stop in IDLE SHALL be ignored.
REQ-033 irq_pend SHALL be sticky until irq_clear=1; when expiry and irq_clear occur in the same cycle, set SHALL win.
REQ-034 irq SHALL follow irq_en combinationally; irq_pend SHALL update regardless of irq_en.
REQ-035 prescale=0 SHALL produce a tick every cycle.
REQ-036 prescale at its maximum value SHALL produce a tick every 2^C_PSC_WIDTH cycles with no overflow.

Reset
REQ-037 ARESETN=0 at a rising edge SHALL force state IDLE, prescaler=0, count=0, busy=0, done_pulse=0, irq_pend=0, irq=0 and expire_cnt=0.
REQ-038 Reset SHALL take priority over all inputs, including mid-RUN and in DONE.
REQ-039 The first start SHALL be honoured in the first cycle after ARESETN returns to 1.

Verification
REQ-040 One-shot: L=3, P=1, start at cycle T -> done_pulse in T+7 only; busy=1 from T+1 to T+6; expire_cnt=1; irq=1 with irq_en=1.
REQ-041 Periodic: L=2, P=0, auto_reload=1 -> done_pulse in T+3, T+5, T+7, ...; stop after the third pulse -> busy=0 and expire_cnt=3.
REQ-042 Abort and restart: L=10, P=0, stop at T+4 -> count=7 held and no done_pulse; start again -> done_pulse 11 cycles later.
REQ-043 Edge cases: L=0 -> done_pulse at T+1 with busy never asserted; expiry coincident with irq_clear -> irq_pend stays 1; start and stop in the same cycle -> IDLE.
REQ-044 Reset mid-RUN: L=100, P=3, ARESETN=0 at T+20 -> all outputs 0 next cycle and no done_pulse afterwards.
REQ-045 Wrap: 256 periodic expiries with L=1, P=0 -> expire_cnt=0 and irq_pend=1.
